// File: rtl/exu_oitf_pkg.sv
// exu_oitf_pkg: widths and pointer type shared by the outstanding instruction track FIFO.
package exu_oitf_pkg;
   localparam int ITAG_WIDTH  = 2;
   localparam int RFIDX_WIDTH = 5;
   localparam int OITF_DEPTH  = 2**ITAG_WIDTH;
   // MSB is the wrap flag that tells full from empty when the indices coincide
   typedef logic [ITAG_WIDTH:0] oitf_ptr_t;
endpackage

// File: rtl/exu_oitf.sv
// exu_oitf: in-order tracker of in-flight long-pipe instructions with RAW/WAW hazard lookup.
module exu_oitf
   import exu_oitf_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   dis_ena,
   output logic                   dis_ready,
   output logic [ITAG_WIDTH-1:0]  dis_ptr,
   input  logic                   dis_rdwen,
   input  logic [RFIDX_WIDTH-1:0] dis_rdidx,
   input  logic                   disp_rs1en,
   input  logic [RFIDX_WIDTH-1:0] disp_rs1idx,
   input  logic                   disp_rs2en,
   input  logic [RFIDX_WIDTH-1:0] disp_rs2idx,
   input  logic                   disp_rdwen,
   input  logic [RFIDX_WIDTH-1:0] disp_rdidx,
   output logic                   oitfrd_match_rs1,
   output logic                   oitfrd_match_rs2,
   output logic                   oitfrd_match_rd,
   input  logic                   ret_ena,
   output logic [ITAG_WIDTH-1:0]  ret_ptr,
   output logic                   ret_rdwen,
   output logic [RFIDX_WIDTH-1:0] ret_rdidx,
   output logic                   oitf_empty
);
   localparam int PTR_W = ITAG_WIDTH;

   function automatic oitf_ptr_t ptr_inc(input oitf_ptr_t p);
      return (p[PTR_W-1:0] == PTR_W'(OITF_DEPTH-1)) ? {~p[PTR_W], {PTR_W{1'b0}}} : p + oitf_ptr_t'(1);
   endfunction

   oitf_ptr_t              alc_q, alc_d, ret_q, ret_d;
   logic [OITF_DEPTH-1:0]  vld_q, rdwen_q, m_rs1, m_rs2, m_rd;
   logic [RFIDX_WIDTH-1:0] rdidx_q [OITF_DEPTH];
   logic                   full, alc_fire, ret_fire;

   assign oitf_empty = (alc_q == ret_q);
   assign full       = (alc_q[PTR_W-1:0] == ret_q[PTR_W-1:0]) & (alc_q[PTR_W] != ret_q[PTR_W]);
   assign dis_ready  = ~full;
   assign alc_fire   = dis_ena & ~full;
   assign ret_fire   = ret_ena & ~oitf_empty;
   assign alc_d      = alc_fire ? ptr_inc(alc_q) : alc_q;
   assign ret_d      = ret_fire ? ptr_inc(ret_q) : ret_q;

   assign dis_ptr    = alc_q[PTR_W-1:0];
   assign ret_ptr    = ret_q[PTR_W-1:0];
   assign ret_rdwen  = vld_q[ret_ptr] & rdwen_q[ret_ptr];
   assign ret_rdidx  = rdidx_q[ret_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alc_q <= '0;
         ret_q <= '0;
      end else begin
         alc_q <= alc_d;
         ret_q <= ret_d;
      end
   end

   // both pointers firing implies neither empty nor full, so they never hit the same slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q   <= '0;
         rdwen_q <= '0;
         for (int k = 0; k < OITF_DEPTH; k++) rdidx_q[k] <= '0;
      end else begin
         if (ret_fire) vld_q[ret_ptr] <= 1'b0;
         if (alc_fire) begin
            vld_q[dis_ptr]   <= 1'b1;
            rdwen_q[dis_ptr] <= dis_rdwen;
            rdidx_q[dis_ptr] <= dis_rdidx;
         end
      end
   end

   for (genvar i = 0; i < OITF_DEPTH; i++) begin : g_ent
      assign m_rs1[i] = vld_q[i] & rdwen_q[i] & disp_rs1en & (rdidx_q[i] == disp_rs1idx);
      assign m_rs2[i] = vld_q[i] & rdwen_q[i] & disp_rs2en & (rdidx_q[i] == disp_rs2idx);
      assign m_rd[i]  = vld_q[i] & rdwen_q[i] & disp_rdwen & (rdidx_q[i] == disp_rdidx);
   end

   // x0 is hardwired zero, so it can never carry a hazard
   assign oitfrd_match_rs1 = (|m_rs1) & (disp_rs1idx != '0);
   assign oitfrd_match_rs2 = (|m_rs2) & (disp_rs2idx != '0);
   assign oitfrd_match_rd  = (|m_rd)  & (disp_rdidx  != '0);
endmodule

// File: tb/tb_exu_oitf.sv
// tb_exu_oitf: directed vectors for exu_oitf; stimulus queues expected outputs, a monitor compares them.
module tb_exu_oitf;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dis_ena = 1'b0, dis_rdwen = 1'b0, ret_ena = 1'b0;
   logic [4:0] dis_rdidx = '0;
   logic       disp_rs1en = 1'b0, disp_rs2en = 1'b0, disp_rdwen = 1'b0;
   logic [4:0] disp_rs1idx = '0, disp_rs2idx = '0, disp_rdidx = '0;
   logic       dis_ready, oitfrd_match_rs1, oitfrd_match_rs2, oitfrd_match_rd, ret_rdwen, oitf_empty;
   logic [1:0] dis_ptr, ret_ptr;
   logic [4:0] ret_rdidx;

   typedef struct {
      string       name;
      logic [14:0] v;
   } exp_t;

   exp_t exp_q[$];
   event smp_ev;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   exu_oitf dut (
      .clk(clk), .rst_n(rst_n),
      .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
      .dis_rdwen(dis_rdwen), .dis_rdidx(dis_rdidx),
      .disp_rs1en(disp_rs1en), .disp_rs1idx(disp_rs1idx),
      .disp_rs2en(disp_rs2en), .disp_rs2idx(disp_rs2idx),
      .disp_rdwen(disp_rdwen), .disp_rdidx(disp_rdidx),
      .oitfrd_match_rs1(oitfrd_match_rs1), .oitfrd_match_rs2(oitfrd_match_rs2),
      .oitfrd_match_rd(oitfrd_match_rd),
      .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdwen(ret_rdwen), .ret_rdidx(ret_rdidx),
      .oitf_empty(oitf_empty)
   );

   // observed bundle: {empty, ready, dis_ptr, ret_ptr, ret_rdwen, ret_rdidx, m_rs1, m_rs2, m_rd}
   always begin
      @(smp_ev);
      while (exp_q.size() != 0) begin
         exp_t e;
         logic [14:0] obs;
         e = exp_q.pop_front();
         obs = {oitf_empty, dis_ready, dis_ptr, ret_ptr, ret_rdwen, ret_rdidx,
                oitfrd_match_rs1, oitfrd_match_rs2, oitfrd_match_rd};
         n_vec++;
         if (obs !== e.v) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
         end
      end
   end

   task automatic chk(input string name, input logic e, input logic rdy, input logic [1:0] dp,
                      input logic [1:0] rp, input logic rw, input logic [4:0] ri,
                      input logic m1, input logic m2, input logic md);
      exp_t x;
      x.name = name;
      x.v = {e, rdy, dp, rp, rw, ri, m1, m2, md};
      exp_q.push_back(x);
      -> smp_ev;
      #1;
   endtask

   task automatic drive(input logic de, input logic rw, input logic [4:0] ri, input logic re);
      @(negedge clk);
      dis_ena = de;
      dis_rdwen = rw;
      dis_rdidx = ri;
      ret_ena = re;
      #1;
   endtask

   task automatic hz(input logic e1, input logic [4:0] i1, input logic e2, input logic [4:0] i2,
                     input logic ed, input logic [4:0] id);
      disp_rs1en = e1; disp_rs1idx = i1;
      disp_rs2en = e2; disp_rs2idx = i2;
      disp_rdwen = ed; disp_rdidx = id;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0);
      hz(1, 0, 1, 0, 1, 0);
      chk("reset_idle", 1, 1, 0, 0, 0, 0, 0, 0, 0);
      hz(0, 0, 0, 0, 0, 0);
      drive(1, 1, 5, 0);
      chk("alloc0", 1, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 6, 0);
      chk("alloc1", 0, 1, 1, 0, 1, 5, 0, 0, 0);
      drive(1, 1, 7, 0);
      chk("alloc2", 0, 1, 2, 0, 1, 5, 0, 0, 0);
      drive(1, 1, 0, 0);
      chk("alloc3", 0, 1, 3, 0, 1, 5, 0, 0, 0);
      drive(1, 1, 9, 0);
      chk("full", 0, 0, 0, 0, 1, 5, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("full_ignore", 0, 0, 0, 0, 1, 5, 0, 0, 0);
      hz(1, 5, 1, 7, 1, 0);
      chk("match_rs1_rs2_rd0", 0, 0, 0, 0, 1, 5, 1, 1, 0);
      hz(0, 5, 0, 7, 1, 6);
      chk("match_en_off_rd6", 0, 0, 0, 0, 1, 5, 0, 0, 1);
      hz(1, 9, 0, 0, 0, 0);
      chk("rejected_not_tracked", 0, 0, 0, 0, 1, 5, 0, 0, 0);
      hz(0, 0, 0, 0, 0, 0);
      drive(1, 1, 9, 1);
      chk("full_ret_and_dis", 0, 0, 0, 0, 1, 5, 0, 0, 0);
      drive(1, 1, 12, 0);
      hz(1, 9, 1, 5, 0, 0);
      chk("after_ret_ready", 0, 1, 0, 1, 1, 6, 0, 0, 0);
      drive(0, 0, 0, 0);
      hz(1, 12, 0, 0, 0, 0);
      chk("wrap_alloc", 0, 0, 1, 1, 1, 6, 1, 0, 0);
      hz(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1);
      chk("drain1", 0, 0, 1, 1, 1, 6, 0, 0, 0);
      drive(0, 0, 0, 1);
      chk("drain2", 0, 1, 1, 2, 1, 7, 0, 0, 0);
      drive(0, 0, 0, 1);
      chk("drain3", 0, 1, 1, 3, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 1);
      chk("drain4", 0, 1, 1, 0, 1, 12, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("drained_empty", 1, 1, 1, 1, 0, 6, 0, 0, 0);
      drive(1, 1, 3, 0);
      drive(1, 0, 4, 0);
      drive(0, 0, 0, 0);
      hz(1, 4, 1, 3, 0, 0);
      chk("two_valid", 0, 1, 3, 1, 1, 3, 0, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", 1, 1, 0, 0, 0, 0, 0, 0, 0);
      hz(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 1, 10, 1);
      chk("empty_alloc_ret", 1, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 11, 1);
      chk("one_valid", 0, 1, 1, 0, 1, 10, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("alloc_ret_steady", 0, 1, 2, 1, 1, 11, 0, 0, 0);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected outputs never compared, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
